// File: rtl/regfile_arb_pkg.sv
// Shared constants for the register-file write arbiter: requester ids, mode
// encodings and the grant-index width helper.
package regfile_arb_pkg;
  localparam int NUM_REQ_DEF = 3;
  localparam int CNT_W_DEF   = 16;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_DBG = 2;

  typedef enum logic {
    PRIO_RR    = 1'b0,
    PRIO_FIXED = 1'b1
  } prio_mode_e;

  function automatic int grant_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational picker: first set request at or after the search start,
// wrapping; fixed mode always starts the search at index 0.
module rr_priority_picker
  import regfile_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int GRANT_W = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  input  logic               mode,
  output logic [NUM_REQ-1:0] gnt,
  output logic [GRANT_W-1:0] idx,
  output logic               any
);

  always_comb begin
    int start;
    int j;
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    start = (mode == PRIO_FIXED) ? 0 : int'(ptr);
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (start + k) % NUM_REQ;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = GRANT_W'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback requesters;
// the accepted write is presented on the port one cycle after acceptance.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter  int NUM_REQ          = NUM_REQ_DEF,
  parameter  int write_addr_width = 4,
  parameter  int reg_width        = 32,
  parameter  int CNT_W            = CNT_W_DEF,
  localparam int GRANT_W          = grant_w(NUM_REQ)
) (
  input  logic                                clk_150_mhz,
  input  logic                                reg_rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*write_addr_width-1:0] req_addr,
  input  logic [NUM_REQ*reg_width-1:0]        req_data,
  input  logic                                prio_mode,
  input  logic                                cnt_clr,
  output logic                                write_en,
  output logic [write_addr_width-1:0]         reg_write_addr,
  output logic [reg_width-1:0]                reg_write_data,
  output logic [GRANT_W-1:0]                  grant_id,
  output logic [CNT_W-1:0]                    contention_cnt
);

  logic [GRANT_W-1:0] rr_ptr;
  logic [GRANT_W-1:0] pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_any;
  logic               accept;
  logic               contended;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .mode (prio_mode),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Ready is suppressed during reset so nothing is accepted and then dropped.
  assign req_ready = reg_rst_n ? pick_gnt : '0;
  assign accept    = reg_rst_n & pick_any;
  assign contended = |(req_valid & ~req_ready);

  always_ff @(posedge clk_150_mhz or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      write_en       <= 1'b0;
      reg_write_addr <= '0;
      reg_write_data <= '0;
      grant_id       <= '0;
      rr_ptr         <= '0;
      contention_cnt <= '0;
    end else begin
      write_en <= accept;
      if (accept) begin
        reg_write_addr <= req_addr[pick_idx*write_addr_width +: write_addr_width];
        reg_write_data <= req_data[pick_idx*reg_width +: reg_width];
        grant_id       <= pick_idx;
        if (prio_mode == PRIO_RR)
          rr_ptr <= (pick_idx == GRANT_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
      end
      if (cnt_clr)
        contention_cnt <= '0;
      else if (contended && contention_cnt != '1)
        contention_cnt <= contention_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a small register-file model.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int GW = 2;
  localparam int CW = 16;

  logic            clk_150_mhz = 1'b0;
  logic            reg_rst_n   = 1'b0;
  logic [N-1:0]    req_valid   = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr    = '0;
  logic [N*DW-1:0] req_data    = '0;
  logic            prio_mode   = 1'b0;
  logic            cnt_clr     = 1'b0;
  logic            write_en;
  logic [AW-1:0]   reg_write_addr;
  logic [DW-1:0]   reg_write_data;
  logic [GW-1:0]   grant_id;
  logic [CW-1:0]   contention_cnt;

  logic [DW-1:0]   rf [16];
  int              n_chk  = 0;
  int              n_fail = 0;

  regfile_write_arbiter #(
    .NUM_REQ(N), .write_addr_width(AW), .reg_width(DW), .CNT_W(CW)
  ) dut (
    .clk_150_mhz(clk_150_mhz), .reg_rst_n(reg_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .prio_mode(prio_mode), .cnt_clr(cnt_clr),
    .write_en(write_en), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data), .grant_id(grant_id),
    .contention_cnt(contention_cnt)
  );

  always #5 clk_150_mhz = ~clk_150_mhz;

  always @(posedge clk_150_mhz)
    if (write_en) rf[reg_write_addr] <= reg_write_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_150_mhz);
    #2;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [31:0] gid,
                        input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(write_en), 32'(we));
    chk({tag, "_gid"}, 32'(grant_id), gid);
    chk({tag, "_addr"}, 32'(reg_write_addr), a);
    chk({tag, "_data"}, reg_write_data, d);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;

    // Reset state, ready forced low while in reset
    req_valid = 3'b111;
    #12;
    chk("rst_ready", 32'(req_ready), 0);
    chk_wr("rst", 1'b0, 0, 0, 0);
    chk("rst_cnt", 32'(contention_cnt), 0);
    reg_rst_n = 1'b1;

    // ALU writes addr 5 while DBG waits; then reset mid-stream
    req_valid = 3'b101;
    set_req(REQ_ALU, 4'd5, 32'h55);
    set_req(REQ_DBG, 4'd9, 32'h99);
    #1 chk("pre_ready", 32'(req_ready), 32'b001);
    tick();
    chk_wr("pre", 1'b1, 0, 5, 32'h55);
    chk("pre_cnt", 32'(contention_cnt), 1);
    reg_rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(write_en), 0);
    chk("midrst_cnt", 32'(contention_cnt), 0);
    #2 reg_rst_n = 1'b1;
    set_req(REQ_ALU, 4'd3, 32'hDEADBEEF);
    #1 chk("post_ready_ptr0", 32'(req_ready), 32'b001);
    tick();
    chk_wr("post", 1'b1, 0, 3, 32'hDEADBEEF);

    // Fresh pointer, then RR fairness with all three valid
    reg_rst_n = 1'b0;
    #1 reg_rst_n = 1'b1;
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), 32'hA0 + 32'(i));
    for (int k = 0; k < 7; k++) begin
      #1 chk("rr_ready", 32'(req_ready), 32'(1) << (k % 3));
      tick();
      chk_wr("rr", 1'b1, 32'(k % 3), 32'(k % 3 + 1), 32'hA0 + 32'(k % 3));
      chk("rr_cnt", 32'(contention_cnt), 32'(k + 1));
    end

    // Fixed priority: ALU starves the others, pointer (now 1) is held
    prio_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("fx_ready", 32'(req_ready), 32'b001);
      tick();
      chk_wr("fx", 1'b1, 0, 1, 32'hA0);
    end
    req_valid = 3'b110;
    #1 chk("fx_drop_ready", 32'(req_ready), 32'b010);
    tick();
    chk_wr("fx_drop", 1'b1, 1, 2, 32'hA1);
    req_valid = 3'b111;
    prio_mode = 1'b0;
    #1 chk("sw_rr_ready", 32'(req_ready), 32'b010);
    tick();
    chk("sw_rr_gid", 32'(grant_id), 1);
    req_valid = 3'b100;
    #1 chk("sw_rr2_ready", 32'(req_ready), 32'b100);
    tick();

    // Same-address collision from pointer 0
    req_valid = 3'b011;
    set_req(REQ_ALU, 4'd7, 32'h11);
    set_req(REQ_LSU, 4'd7, 32'h22);
    #1 chk("col1_ready", 32'(req_ready), 32'b001);
    tick();
    chk_wr("col1", 1'b1, 0, 7, 32'h11);
    req_valid = 3'b010;
    #1 chk("col2_ready", 32'(req_ready), 32'b010);
    tick();
    chk_wr("col2", 1'b1, 1, 7, 32'h22);
    chk("col_rf_mid", rf[7], 32'h11);
    req_valid = 3'b000;
    tick();
    chk("col_rf_final", rf[7], 32'h22);
    chk("idle_we", 32'(write_en), 0);
    chk("idle_addr_hold", 32'(reg_write_addr), 7);

    // Contention counter saturation and clear
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cnt", 32'(contention_cnt), 0);
    prio_mode = 1'b1;
    req_valid = 3'b111;
    for (int k = 0; k < 100; k++) tick();
    chk("cnt_100", 32'(contention_cnt), 100);
    for (int k = 100; k < 65541; k++) tick();
    chk("cnt_sat", 32'(contention_cnt), 32'hFFFF);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clr_pri", 32'(contention_cnt), 0);
    tick();
    chk("cnt_after_clr", 32'(contention_cnt), 1);

    // Sparse DBG writes every third cycle
    prio_mode = 1'b0;
    req_valid = 3'b000;
    for (int r = 0; r < 3; r++) begin
      req_valid = 3'b100;
      set_req(REQ_DBG, AW'(8 + r), 32'hD0 + 32'(r));
      #1 chk("sp_ready", 32'(req_ready), 32'b100);
      tick();
      req_valid = 3'b000;
      chk_wr("sp", 1'b1, 2, 32'(8 + r), 32'hD0 + 32'(r));
      tick();
      chk("sp_gap1_we", 32'(write_en), 0);
      tick();
      chk("sp_gap2_we", 32'(write_en), 0);
    end
    chk("sp_cnt", 32'(contention_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
